// File: rtl/memory_stage.sv
// MIPS MEM stage: word-addressed synchronous data RAM, one-cycle ALU/store results and a two-cycle load path.
// Byte loads/stores (LB, LBU, SB) are built in only when MS_BYTE_ACCESS_EN is defined.
`ifndef OPCODE_WIDTH
  `define OPCODE_WIDTH 6
`endif
`ifndef FUNCT_WIDTH
  `define FUNCT_WIDTH 6
`endif
`ifndef DWIDTH
  `define DWIDTH 32
`endif
`ifndef PC_WIDTH
  `define PC_WIDTH 32
`endif
`ifndef LW
  `define LW 6'h23
`endif
`ifndef SW
  `define SW 6'h2b
`endif
`ifndef LB
  `define LB 6'h20
`endif
`ifndef LBU
  `define LBU 6'h24
`endif
`ifndef SB
  `define SB 6'h28
`endif

module memory_stage #(
  parameter int DEPTH  = 256,
  parameter int AWIDTH = 8
) (
  input  logic                     ms_clk,
  input  logic                     ms_rst,
  input  logic                     ms_i_ce,
  input  logic                     ms_i_stall,
  input  logic                     ms_i_flush,
  input  logic [`OPCODE_WIDTH-1:0] ms_i_opcode,
  input  logic [`FUNCT_WIDTH-1:0]  ms_i_funct,
  input  logic [`DWIDTH-1:0]       ms_i_alu_value,
  input  logic [`DWIDTH-1:0]       ms_i_data_rt,
  input  logic [`PC_WIDTH-1:0]     ms_i_pc,
  input  logic [4:0]               ms_i_reg_dest,
  input  logic                     ms_i_reg_write,
  output logic                     ms_o_ce,
  output logic [`DWIDTH-1:0]       ms_o_wb_data,
  output logic [4:0]               ms_o_reg_dest,
  output logic                     ms_o_reg_write,
  output logic [`OPCODE_WIDTH-1:0] ms_o_opcode,
  output logic [`FUNCT_WIDTH-1:0]  ms_o_funct,
  output logic [`PC_WIDTH-1:0]     ms_o_pc,
  output logic                     ms_o_misaligned,
  output logic                     ms_o_stall
);

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  localparam logic [1:0] KIND_WORD  = 2'd0;
  localparam logic [1:0] KIND_SBYTE = 2'd1;
  localparam logic [1:0] KIND_UBYTE = 2'd2;

  state_t state_q, state_d;

  logic [`DWIDTH-1:0] ram [DEPTH];
  logic [`DWIDTH-1:0] rd_q;

  logic [AWIDTH-1:0]  addr;
  logic [1:0]         lane;
  logic               is_lw, is_sw, is_store, is_load, misaligned, byte_nop;
  logic               accept, mem_wr;
  logic [1:0]         kind;
  logic [3:0]         wr_be;
  logic [`DWIDTH-1:0] wr_data;

  logic [1:0]               ld_kind_q, ld_lane_q;
  logic [4:0]               ld_dest_q;
  logic                     ld_wr_q;
  logic [`OPCODE_WIDTH-1:0] ld_op_q;
  logic [`FUNCT_WIDTH-1:0]  ld_fn_q;
  logic [`PC_WIDTH-1:0]     ld_pc_q;

  // Address bits above the RAM index are deliberately dropped so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, ms_i_alu_value[`DWIDTH-1:AWIDTH+2]};

  function automatic logic [`DWIDTH-1:0] load_format(input logic [`DWIDTH-1:0] word,
                                                     input logic [1:0] knd,
                                                     input logic [1:0] ln);
    logic [7:0] b;
    b = word[8*ln +: 8];
    case (knd)
      KIND_SBYTE: return {{(`DWIDTH-8){b[7]}}, b};
      KIND_UBYTE: return {{(`DWIDTH-8){1'b0}}, b};
      default:    return word;
    endcase
  endfunction

  assign lane       = ms_i_alu_value[1:0];
  assign addr       = ms_i_alu_value[AWIDTH+1:2];
  assign is_lw      = (ms_i_opcode == `LW);
  assign is_sw      = (ms_i_opcode == `SW);
  assign misaligned = (is_lw || is_sw) && (lane != 2'b00);
  assign accept     = (state_q == IDLE) && ms_i_ce && !ms_i_stall && !ms_i_flush && !ms_o_stall;

`ifdef MS_BYTE_ACCESS_EN
  logic is_lb, is_lbu, is_sb;
  assign is_lb    = (ms_i_opcode == `LB);
  assign is_lbu   = (ms_i_opcode == `LBU);
  assign is_sb    = (ms_i_opcode == `SB);
  assign byte_nop = 1'b0;
  assign is_store = is_sw || is_sb;
  assign is_load  = (is_lw && !misaligned) || is_lb || is_lbu;
  assign kind     = is_lb ? KIND_SBYTE : (is_lbu ? KIND_UBYTE : KIND_WORD);
  assign mem_wr   = accept && ((is_sw && !misaligned) || is_sb);
  assign wr_be    = is_sb ? (4'b0001 << lane) : 4'b1111;
  assign wr_data  = is_sb ? {4{ms_i_data_rt[7:0]}} : ms_i_data_rt;
`else
  // Without byte support these opcodes retire as plain no-ops.
  assign byte_nop = (ms_i_opcode == `LB) || (ms_i_opcode == `LBU) || (ms_i_opcode == `SB);
  assign is_store = is_sw;
  assign is_load  = is_lw && !misaligned;
  assign kind     = KIND_WORD;
  assign mem_wr   = accept && is_sw && !misaligned;
  assign wr_be    = 4'b1111;
  assign wr_data  = ms_i_data_rt;
`endif

  always_ff @(posedge ms_clk or negedge ms_rst) begin
    if (!ms_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ms_i_flush)                 state_d = IDLE;
    else if (!ms_i_stall) begin
      if (state_q == LOAD)          state_d = IDLE;
      else if (accept && is_load)   state_d = LOAD;
    end
  end

  always_comb begin
    ms_o_stall = (state_q == LOAD);
  end

  // RAM: write on the accept edge, read issued on the accept edge of a load.
  always_ff @(posedge ms_clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) ram[addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (accept && is_load) rd_q <= ram[addr];
  end

  always_ff @(posedge ms_clk) begin
    if (accept && is_load) begin
      ld_kind_q <= kind;
      ld_lane_q <= lane;
      ld_dest_q <= ms_i_reg_dest;
      ld_wr_q   <= ms_i_reg_write;
      ld_op_q   <= ms_i_opcode;
      ld_fn_q   <= ms_i_funct;
      ld_pc_q   <= ms_i_pc;
    end
  end

  // Write-back payload toward WB.
  always_ff @(posedge ms_clk or negedge ms_rst) begin
    if (!ms_rst) begin
      ms_o_ce         <= 1'b0;
      ms_o_wb_data    <= '0;
      ms_o_reg_dest   <= '0;
      ms_o_reg_write  <= 1'b0;
      ms_o_opcode     <= '0;
      ms_o_funct      <= '0;
      ms_o_pc         <= '0;
      ms_o_misaligned <= 1'b0;
    end else if (ms_i_flush) begin
      ms_o_ce         <= 1'b0;
      ms_o_reg_write  <= 1'b0;
      ms_o_misaligned <= 1'b0;
    end else if (!ms_i_stall) begin
      if (state_q == LOAD) begin
        ms_o_ce         <= 1'b1;
        ms_o_wb_data    <= load_format(rd_q, ld_kind_q, ld_lane_q);
        ms_o_reg_dest   <= ld_dest_q;
        ms_o_reg_write  <= ld_wr_q;
        ms_o_opcode     <= ld_op_q;
        ms_o_funct      <= ld_fn_q;
        ms_o_pc         <= ld_pc_q;
        ms_o_misaligned <= 1'b0;
      end else if (accept && is_load) begin
        ms_o_ce         <= 1'b0;
        ms_o_reg_write  <= 1'b0;
        ms_o_misaligned <= 1'b0;
      end else if (accept) begin
        ms_o_ce         <= 1'b1;
        ms_o_wb_data    <= ms_i_alu_value;
        ms_o_reg_dest   <= ms_i_reg_dest;
        ms_o_reg_write  <= ms_i_reg_write && !is_store && !misaligned && !byte_nop;
        ms_o_opcode     <= ms_i_opcode;
        ms_o_funct      <= ms_i_funct;
        ms_o_pc         <= ms_i_pc;
        ms_o_misaligned <= misaligned;
      end else begin
        ms_o_ce         <= 1'b0;
        ms_o_reg_write  <= 1'b0;
        ms_o_misaligned <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed steps plus randomized instructions checked against an array-based memory model.
`ifndef OPCODE_WIDTH
  `define OPCODE_WIDTH 6
`endif
`ifndef FUNCT_WIDTH
  `define FUNCT_WIDTH 6
`endif
`ifndef DWIDTH
  `define DWIDTH 32
`endif
`ifndef PC_WIDTH
  `define PC_WIDTH 32
`endif
`ifndef LW
  `define LW 6'h23
`endif
`ifndef SW
  `define SW 6'h2b
`endif
`ifndef LB
  `define LB 6'h20
`endif
`ifndef LBU
  `define LBU 6'h24
`endif
`ifndef SB
  `define SB 6'h28
`endif
`ifndef RTYPE
  `define RTYPE 6'h00
`endif
`ifndef OR
  `define OR 6'h25
`endif

module tb_memory_stage;

`ifdef MS_BYTE_ACCESS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  localparam logic [5:0] LW_OP  = `LW;
  localparam logic [5:0] SW_OP  = `SW;
  localparam logic [5:0] LB_OP  = `LB;
  localparam logic [5:0] LBU_OP = `LBU;
  localparam logic [5:0] SB_OP  = `SB;
  localparam logic [5:0] RT_OP  = `RTYPE;
  localparam logic [5:0] OR_FN  = `OR;

  logic        ms_clk = 1'b0;
  logic        ms_rst;
  logic        ms_i_ce, ms_i_stall, ms_i_flush, ms_i_reg_write;
  logic [5:0]  ms_i_opcode, ms_i_funct;
  logic [31:0] ms_i_alu_value, ms_i_data_rt, ms_i_pc;
  logic [4:0]  ms_i_reg_dest;
  logic        ms_o_ce, ms_o_reg_write, ms_o_misaligned, ms_o_stall;
  logic [31:0] ms_o_wb_data, ms_o_pc;
  logic [4:0]  ms_o_reg_dest;
  logic [5:0]  ms_o_opcode, ms_o_funct;

  memory_stage #(.DEPTH(256), .AWIDTH(8)) dut (
    .ms_clk(ms_clk), .ms_rst(ms_rst), .ms_i_ce(ms_i_ce), .ms_i_stall(ms_i_stall),
    .ms_i_flush(ms_i_flush), .ms_i_opcode(ms_i_opcode), .ms_i_funct(ms_i_funct),
    .ms_i_alu_value(ms_i_alu_value), .ms_i_data_rt(ms_i_data_rt), .ms_i_pc(ms_i_pc),
    .ms_i_reg_dest(ms_i_reg_dest), .ms_i_reg_write(ms_i_reg_write),
    .ms_o_ce(ms_o_ce), .ms_o_wb_data(ms_o_wb_data), .ms_o_reg_dest(ms_o_reg_dest),
    .ms_o_reg_write(ms_o_reg_write), .ms_o_opcode(ms_o_opcode), .ms_o_funct(ms_o_funct),
    .ms_o_pc(ms_o_pc), .ms_o_misaligned(ms_o_misaligned), .ms_o_stall(ms_o_stall)
  );

  always #5 ms_clk = ~ms_clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [31:0] mem [256];
  logic [31:0] e_wb, e_pc;
  logic [4:0]  e_dest;
  logic [5:0]  e_op, e_fn;
  logic        e_wr, e_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic exp_ce);
    chk({tag, ".ce"},    32'(ms_o_ce),         32'(exp_ce));
    chk({tag, ".wb"},    ms_o_wb_data,         e_wb);
    chk({tag, ".dest"},  32'(ms_o_reg_dest),   32'(e_dest));
    chk({tag, ".wr"},    32'(ms_o_reg_write),  32'(e_wr));
    chk({tag, ".op"},    32'(ms_o_opcode),     32'(e_op));
    chk({tag, ".fn"},    32'(ms_o_funct),      32'(e_fn));
    chk({tag, ".pc"},    ms_o_pc,              e_pc);
    chk({tag, ".mis"},   32'(ms_o_misaligned), 32'(e_mis));
    chk({tag, ".stall"}, 32'(ms_o_stall),      32'h0);
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] dest, input logic wr,
                       input logic [31:0] pc);
    ms_i_ce = 1'b1; ms_i_opcode = op; ms_i_funct = fn; ms_i_alu_value = alu;
    ms_i_data_rt = rt; ms_i_reg_dest = dest; ms_i_reg_write = wr; ms_i_pc = pc;
  endtask

  // Reference: one instruction issued from IDLE, result predicted from the memory array.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] alu, input logic [31:0] rt,
                           input logic [4:0] dest, input logic wr);
    logic [31:0] pc;
    logic [7:0]  w;
    logic [1:0]  ln;
    logic [7:0]  byt;
    logic        mis, ld, byte_op;
    pc = $urandom;
    w  = alu[9:2];
    ln = alu[1:0];
    byte_op = (op == LB_OP) || (op == LBU_OP) || (op == SB_OP);
    mis = ((op == LW_OP) || (op == SW_OP)) && (ln != 2'b00);
    ld  = ((op == LW_OP) && !mis) || (BYTE_EN && ((op == LB_OP) || (op == LBU_OP)));
    drive(op, fn, alu, rt, dest, wr, pc);
    @(posedge ms_clk); #1;
    if (ld) begin
      chk({tag, ".acc_ce"},    32'(ms_o_ce),    32'h0);
      chk({tag, ".acc_stall"}, 32'(ms_o_stall), 32'h1);
      @(posedge ms_clk); #1;
      byt = mem[w] >> (8 * ln);
      if (op == LB_OP)       e_wb = {{24{byt[7]}}, byt};
      else if (op == LBU_OP) e_wb = {24'h0, byt};
      else                   e_wb = mem[w];
      e_wr  = wr;
      e_mis = 1'b0;
    end else begin
      e_wb  = alu;
      e_wr  = wr && !mis && (op != SW_OP) && (op != SB_OP) && (BYTE_EN || !byte_op);
      e_mis = mis;
      if ((op == SW_OP) && !mis) mem[w] = rt;
      if (BYTE_EN && (op == SB_OP)) mem[w][8*ln +: 8] = rt[7:0];
    end
    e_dest = dest; e_op = op; e_fn = fn; e_pc = pc;
    check_out(tag, 1'b1);
    ms_i_ce = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    ms_i_ce = 1'b0;
    ms_i_opcode = 6'($urandom); ms_i_alu_value = $urandom; ms_i_reg_write = 1'($urandom);
    @(posedge ms_clk); #1;
    e_wr = 1'b0; e_mis = 1'b0;
    check_out(tag, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  ops [8];
    logic [5:0]  op;
    logic [31:0] alu;
    ops = '{RT_OP, 6'h08, 6'h0d, LW_OP, SW_OP, LB_OP, LBU_OP, SB_OP};

    ms_rst = 1'b0;
    ms_i_ce = 0; ms_i_stall = 0; ms_i_flush = 0; ms_i_reg_write = 0;
    ms_i_opcode = 0; ms_i_funct = 0; ms_i_alu_value = 0; ms_i_data_rt = 0;
    ms_i_pc = 0; ms_i_reg_dest = 0;
    e_wb = 0; e_pc = 0; e_dest = 0; e_op = 0; e_fn = 0; e_wr = 0; e_mis = 0;
    repeat (3) @(posedge ms_clk);
    #1;
    check_out("reset", 1'b0);
    ms_rst = 1'b1;

    for (int i = 0; i < 256; i++)
      run_instr("fill", SW_OP, 6'($urandom), 32'(i * 4), $urandom, 5'($urandom), 1'b1);

    run_instr("rtype_or", RT_OP, OR_FN, 32'd5, 32'($urandom), 5'd3, 1'b1);

    run_instr("sw8", SW_OP, 6'd0, 32'd8, 32'hDEADBEEF, 5'd0, 1'b0);
    run_instr("lw8", LW_OP, 6'd0, 32'd8, 32'd0, 5'd4, 1'b1);

    run_instr("sw_mis6", SW_OP, 6'd0, 32'd6, 32'h11, 5'd2, 1'b1);
    idle_cycle("mis_clear");
    run_instr("lw4_after_mis", LW_OP, 6'd0, 32'd4, 32'd0, 5'd5, 1'b1);
    run_instr("lw_mis", LW_OP, 6'd0, 32'd13, 32'd0, 5'd6, 1'b1);

    // Stall while idle with a store presented: outputs frozen, store not taken.
    run_instr("pre_stall", RT_OP, OR_FN, 32'h1234, 32'd0, 5'd7, 1'b1);
    drive(SW_OP, 6'd0, 32'd20, 32'hCAFEF00D, 5'd1, 1'b1, 32'h40);
    ms_i_stall = 1'b1;
    repeat (2) begin
      @(posedge ms_clk); #1;
      check_out("stall_idle", 1'b1);
    end
    ms_i_stall = 1'b0;
    ms_i_ce = 1'b0;
    run_instr("lw20_after_stall", LW_OP, 6'd0, 32'd20, 32'd0, 5'd8, 1'b1);

    // Stall then flush during LOAD.
    drive(LW_OP, 6'd0, 32'd12, 32'd0, 5'd9, 1'b1, 32'h80);
    @(posedge ms_clk); #1;
    chk("flush_ld.acc_stall", 32'(ms_o_stall), 32'h1);
    ms_i_stall = 1'b1;
    repeat (3) begin
      @(posedge ms_clk); #1;
      chk("stall_ld.ce",    32'(ms_o_ce),    32'h0);
      chk("stall_ld.stall", 32'(ms_o_stall), 32'h1);
    end
    ms_i_stall = 1'b0; ms_i_flush = 1'b1;
    @(posedge ms_clk); #1;
    chk("flush_ld.ce",    32'(ms_o_ce),        32'h0);
    chk("flush_ld.stall", 32'(ms_o_stall),     32'h0);
    chk("flush_ld.wr",    32'(ms_o_reg_write), 32'h0);
    ms_i_flush = 1'b0; ms_i_ce = 1'b0;
    @(posedge ms_clk); #1;
    chk("post_flush.ce",  32'(ms_o_ce),        32'h0);
    chk("post_flush.wr",  32'(ms_o_reg_write), 32'h0);
    chk("post_flush.mis", 32'(ms_o_misaligned), 32'h0);

    // Flush wins over an accept: the store must not land.
    drive(SW_OP, 6'd0, 32'd16, 32'h55, 5'd0, 1'b0, 32'hC0);
    ms_i_flush = 1'b1;
    @(posedge ms_clk); #1;
    chk("flush_sw.ce", 32'(ms_o_ce), 32'h0);
    ms_i_flush = 1'b0; ms_i_ce = 1'b0;
    run_instr("lw16_after_flush", LW_OP, 6'd0, 32'd16, 32'd0, 5'd10, 1'b1);

    run_instr("sw_wrap", SW_OP, 6'd0, 32'h400, 32'd7, 5'd0, 1'b0);
    run_instr("lw0_wrap", LW_OP, 6'd0, 32'd0, 32'd0, 5'd11, 1'b1);

    run_instr("sb1", SB_OP, 6'd0, 32'd1, 32'h80, 5'd12, 1'b1);
    run_instr("lb1", LB_OP, 6'd0, 32'd1, 32'd0, 5'd13, 1'b1);
    run_instr("lbu1", LBU_OP, 6'd0, 32'd1, 32'd0, 5'd14, 1'b1);
    run_instr("lw0_after_sb", LW_OP, 6'd0, 32'd0, 32'd0, 5'd15, 1'b1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) begin
        idle_cycle("rand_idle");
      end else begin
        op  = ops[$urandom_range(7)];
        alu = $urandom;
        if (((op == LW_OP) || (op == SW_OP)) && ($urandom_range(3) != 0)) alu[1:0] = 2'b00;
        run_instr("rand", op, 6'($urandom), alu, $urandom, 5'($urandom), 1'($urandom));
      end
    end

    // Asynchronous reset in the middle of a load.
    drive(LW_OP, 6'd0, 32'd4, 32'd0, 5'd1, 1'b1, 32'h100);
    @(posedge ms_clk); #1;
    chk("rst_ld.acc_stall", 32'(ms_o_stall), 32'h1);
    ms_rst = 1'b0; ms_i_ce = 1'b0;
    #1;
    e_wb = 0; e_pc = 0; e_dest = 0; e_op = 0; e_fn = 0; e_wr = 0; e_mis = 0;
    check_out("rst_mid_load", 1'b0);
    @(posedge ms_clk); #1;
    ms_rst = 1'b1;
    run_instr("after_rst", RT_OP, OR_FN, 32'h99, 32'd0, 5'd17, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the MIPS pipeline; consumer of the execute stage's ALU result, opcode, PC and rt data.
- Holds the data memory: a word-addressed synchronous RAM. Performs loads and stores.
- Registers the write-back payload toward the WB stage. Raises back-pressure toward execute while a load completes.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory.
- AWIDTH, 8, word-address width; DEPTH = 2**AWIDTH.

Ports:
- ms_clk  in  1  clock, rising edge.
- ms_rst  in  1  asynchronous active-low reset.
- ms_i_ce  in  1  input valid from execute.
- ms_i_stall  in  1  downstream (WB) stall; freezes this stage.
- ms_i_flush  in  1  kill in-flight instruction.
- ms_i_opcode  in  `OPCODE_WIDTH  opcode from execute.
- ms_i_funct  in  `FUNCT_WIDTH  funct from execute (passed through).
- ms_i_alu_value  in  `DWIDTH  ALU result; byte address for LW/SW.
- ms_i_data_rt  in  `DWIDTH  store data.
- ms_i_pc  in  `PC_WIDTH  instruction PC.
- ms_i_reg_dest  in  5  destination register.
- ms_i_reg_write  in  1  register write enable.
- ms_o_ce  out  1  output valid to WB.
- ms_o_wb_data  out  `DWIDTH  load data or passed-through ALU value.
- ms_o_reg_dest  out  5  destination register.
- ms_o_reg_write  out  1  qualified register write enable.
- ms_o_opcode  out  `OPCODE_WIDTH  registered opcode.
- ms_o_funct  out  `FUNCT_WIDTH  registered funct.
- ms_o_pc  out  `PC_WIDTH  registered PC.
- ms_o_misaligned  out  1  alignment fault flag, valid with ms_o_ce.
- ms_o_stall  out  1  back-pressure to execute; inputs must be held while high.

Behaviour:
- Reset (ms_rst=0, async):
  - All outputs go to 0. FSM goes to IDLE.
  - RAM contents are not reset.
- FSM states:
  - IDLE: accepts a new instruction when ms_i_ce=1, ms_i_stall=0 and ms_o_stall=0.
  - LOAD: RAM read in flight. ms_o_stall=1, registered, high only in LOAD. Inputs are ignored in LOAD.
- Word address = ms_i_alu_value[AWIDTH+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH.
- Non-memory opcode, on the accept edge:
  - ms_o_ce=1, ms_o_wb_data=ms_i_alu_value.
  - reg_dest, reg_write, opcode, funct and pc pass through.
  - Latency 1 cycle.
- `SW, on the accept edge:
  - RAM[addr] <= ms_i_data_rt.
  - ms_o_ce=1, ms_o_reg_write=0, ms_o_wb_data=ms_i_alu_value.
  - Latency 1 cycle.
- `LW, on the accept edge:
  - Read is issued. FSM goes IDLE->LOAD. ms_o_ce=0.
  - On the next edge: ms_o_wb_data=RAM[addr], ms_o_ce=1, reg fields from the captured instruction, FSM goes LOAD->IDLE.
  - Latency 2 cycles. Accept-to-accept spacing is 2 cycles.
- Misaligned LW/SW (ms_i_alu_value[1:0]!=0):
  - No RAM write, no LOAD state.
  - 1-cycle result with ms_o_misaligned=1, ms_o_reg_write=0.
- Clearing rules:
  - ms_o_misaligned clears on the next accepted or idle edge.
  - ms_i_ce=0 in IDLE: next edge ms_o_ce=0, ms_o_reg_write=0, other outputs hold.
- ms_i_stall=1: all registers, FSM and RAM hold. No write, no state change. In LOAD, completion waits.
- ms_i_flush=1:
  - Priority over stall and accept.
  - Next edge: ms_o_ce=0, ms_o_reg_write=0, FSM to IDLE, ms_o_stall=0.
  - A pending load is discarded. A store in the same cycle is not written.
- Same-address SW then LW returns the new data (read occurs a cycle after the write).

Optional Feature:
- Macro: MS_BYTE_ACCESS_EN.
- Defined:
  - `LB, `LBU, `SB are supported; the byte lane is selected by address[1:0]. No misalignment fault for these.
  - `SB writes one byte lane only.
  - `LB sign-extends. `LBU zero-extends.
  - Loads use the same 2-cycle LOAD path as `LW.
- Undefined:
  - These opcodes behave as non-memory NOPs: 1 cycle, ms_o_reg_write=0, no RAM access.

Test Plan:
- Reset mid-LOAD: ms_rst=0 one cycle -> all outputs 0 immediately, ms_o_stall=0, FSM IDLE.
- R-type passthrough: opcode `RTYPE, funct `OR, alu_value=5, reg_dest=3, reg_write=1 -> next edge ms_o_ce=1, wb_data=5, reg_dest=3, reg_write=1.
- Store then load: SW alu_value=8, rt=0xDEADBEEF; then LW alu_value=8, reg_dest=4:
  - ms_o_stall=1 for one cycle.
  - wb_data=0xDEADBEEF 2 cycles after LW accept, reg_write=1.
- Misaligned SW at alu_value=6, rt=0x11 -> ms_o_misaligned=1, reg_write=0; subsequent LW at 4 returns prior RAM[1] contents unchanged.
- Stall then flush during LOAD:
  - ms_i_stall=1 for 3 cycles -> outputs frozen.
  - Then ms_i_flush=1 -> ms_o_ce=0, ms_o_stall=0, no write-back.
- Wrap (DEPTH=256): SW at alu_value=0x400, rt=7; LW at 0 -> wb_data=7.
  - With MS_BYTE_ACCESS_EN: SB at address 1 with rt=0x80 -> LB at 1 returns 0xFFFFFF80; LBU returns 0x00000080.
